// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: widths, defaults,
// I/O region decode and FSM state encodings.
package icache_pkg;

    localparam int ADDR_LEN       = 32;
    localparam int INST_LEN       = 32;
    localparam int INDEX_BITS_DEF = 7;
    localparam int ADDR_BITS_DEF  = 18;

    // addr[17:16] == 2'b11 selects memory-mapped I/O
    localparam logic [1:0] IO_REGION = 2'b11;

    localparam logic IDLE = 1'b0;
    localparam logic MISS = 1'b1;

    function automatic logic is_io(input logic [1:0] hi);
        return hi == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// Ports: combinational read (rd_*), one write port (we/wr_*), async clear of valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = 9,
    parameter int DATA_BITS  = INST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags [LINES];
    logic [DATA_BITS-1:0] data [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between ifetch and mem_ctrl.
// Ports: clk/rst/rdy, flush, if_* (ifetch side), mc_* (mem_ctrl side).
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                if_request,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_enable,
    output logic                mc_request,
    output logic [ADDR_LEN-1:0] mc_addr,
    input  logic [INST_LEN-1:0] mc_inst,
    input  logic                mc_enable
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    logic                  state;
    logic                  cancel;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  miss_io;

    logic [INDEX_BITS-1:0] cur_index;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  cur_io;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INST_LEN-1:0]   rd_data;
    logic                  hit;
    logic                  fill_we;
    logic                  unused_ok;

    assign cur_index = if_addr[INDEX_BITS+1:2];
    assign cur_tag   = if_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign cur_io    = is_io(if_addr[ADDR_BITS-1:ADDR_BITS-2]);
    assign unused_ok = ^if_addr[1:0];

    // I/O words are never cached, so they can never hit.
    assign hit = rd_valid && (rd_tag == cur_tag) && !cur_io;

    assign fill_we = rdy && (state == MISS) && mc_enable && !miss_io;

    icache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (INST_LEN)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_index(cur_index),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (fill_we),
        .wr_index(miss_index),
        .wr_tag  (miss_tag),
        .wr_data (mc_inst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            miss_index <= '0;
            miss_tag   <= '0;
            miss_io    <= 1'b0;
            if_enable  <= 1'b0;
            if_inst    <= '0;
            mc_request <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            if_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_request && !flush) begin
                        if (hit) begin
                            if_enable <= 1'b1;
                            if_inst   <= rd_data;
                        end else begin
                            mc_request <= 1'b1;
                            mc_addr    <= {if_addr[ADDR_LEN-1:2], 2'b00};
                            miss_index <= cur_index;
                            miss_tag   <= cur_tag;
                            miss_io    <= cur_io;
                            state      <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_enable) begin
                        mc_request <= 1'b0;
                        state      <= IDLE;
                        cancel     <= 1'b0;
                        // A flush on the fill edge also cancels delivery.
                        if (!cancel && !flush) begin
                            if_enable <= 1'b1;
                            if_inst   <= mc_inst;
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed stimulus pushes expected words,
// a negedge monitor pops and compares each if_enable pulse.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_request = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_inst;
    logic        if_enable;
    logic        mc_request;
    logic [31:0] mc_addr;
    logic [31:0] mc_inst = '0;
    logic        mc_enable = 1'b0;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .if_request(if_request),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_enable (if_enable),
        .mc_request(mc_request),
        .mc_addr   (mc_addr),
        .mc_inst   (mc_inst),
        .mc_enable (mc_enable)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && if_enable) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected if_enable", 32'd1, 32'd0);
            end else begin
                check("if_inst", if_inst, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w);
        exp_pulses++;
    endtask

    task automatic issue(input logic [31:0] a);
        if_request = 1'b1;
        if_addr    = a;
        tick();
        if_request = 1'b0;
    endtask

    task automatic mem_reply(input logic [31:0] a, input logic [31:0] d,
                             input int waits, input logic fl);
        for (int i = 0; i < waits; i++) begin
            check("mc_request held", {31'd0, mc_request}, 32'd1);
            check("mc_addr held", mc_addr, a);
            tick();
        end
        mc_enable = 1'b1;
        mc_inst   = d;
        flush     = fl;
        tick();
        mc_enable = 1'b0;
        flush     = 1'b0;
        check("mc_request drop", {31'd0, mc_request}, 32'd0);
    endtask

    task automatic miss_fill(input logic [31:0] a, input logic [31:0] d,
                             input logic deliver);
        issue(a);
        check("miss mc_request", {31'd0, mc_request}, 32'd1);
        check("miss mc_addr", mc_addr, a);
        if (deliver) expect_word(d);
        mem_reply(a, d, 2, 1'b0);
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        expect_word(d);
        issue(a);
        check("hit no mc_request", {31'd0, mc_request}, 32'd0);
        check("hit if_enable", {31'd0, if_enable}, 32'd1);
        tick();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst if_enable", {31'd0, if_enable}, 32'd0);
        check("rst if_inst", if_inst, 32'd0);
        check("rst mc_request", {31'd0, mc_request}, 32'd0);
        check("rst mc_addr", mc_addr, 32'd0);
        rst = 1'b1;
        tick();

        // cold miss, three-cycle memory latency, then hit
        miss_fill(32'h4, 32'h13, 1'b1);
        tick();
        hit(32'h4, 32'h13);

        // aliasing: 0x210 evicts 0x10
        miss_fill(32'h10, 32'h1111_1111, 1'b1);
        miss_fill(32'h210, 32'h2222_2222, 1'b1);
        miss_fill(32'h10, 32'h1111_1111, 1'b1);
        hit(32'h210 - 32'h200, 32'h1111_1111);

        // flush during miss: no delivery, line filled
        issue(32'h100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_reply(32'h100, 32'hDEAD_BEEF, 1, 1'b0);
        tick();
        check("flush-miss pulses", pulses, exp_pulses);
        hit(32'h100, 32'hDEAD_BEEF);

        // flush on the same edge as mc_enable
        issue(32'h180);
        mem_reply(32'h180, 32'hCAFE_F00D, 1, 1'b1);
        tick();
        check("flush-fill pulses", pulses, exp_pulses);
        hit(32'h180, 32'hCAFE_F00D);

        // flush with request in IDLE
        flush = 1'b1;
        issue(32'h200);
        flush = 1'b0;
        check("idle flush mc_request", {31'd0, mc_request}, 32'd0);
        tick();
        check("idle flush pulses", pulses, exp_pulses);

        // rdy low mid-miss; stray mc_enable while frozen is ignored
        issue(32'h300);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mc_enable = (i == 2);
            mc_inst   = 32'hBAD0_BAD0;
            tick();
            check("frozen mc_request", {31'd0, mc_request}, 32'd1);
            check("frozen mc_addr", mc_addr, 32'h300);
        end
        mc_enable = 1'b0;
        rdy = 1'b1;
        check("frozen pulses", pulses, exp_pulses);
        expect_word(32'h33);
        mem_reply(32'h300, 32'h33, 1, 1'b0);
        tick();
        hit(32'h300, 32'h33);

        // asynchronous reset mid-miss
        issue(32'h8);
        #2;
        rst = 1'b0;
        #1;
        check("async rst mc_request", {31'd0, mc_request}, 32'd0);
        check("async rst if_enable", {31'd0, if_enable}, 32'd0);
        check("async rst mc_addr", mc_addr, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        miss_fill(32'h4, 32'h13, 1'b1);
        tick();

        // I/O region never cached
        miss_fill(32'h0003_0000, 32'h77, 1'b1);
        tick();
        miss_fill(32'h0003_0000, 32'h78, 1'b1);
        tick();
        tick();

        check("total pulses", pulses, exp_pulses);
        check("queue drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
